// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU datapath vs loader/debug port, with
// starvation guard and locked loader bursts. Optional DMEM_ARB_PERF_EN adds a conflict counter.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic        ldr_lock,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic        ldr_gnt,
  output logic        ldr_rvalid,
  output logic [31:0] ldr_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [15:0] conflict_cnt
);

  // state | meaning
  // ARB   | normal arbitration, CPU priority unless loader is starved
  // BURST | loader holds the port while ldr_lock is set, CPU stalled
  typedef enum logic {ARB, BURST} state_t;

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_starve_cnt, w_starve_nxt;
  logic [BW-1:0]   r_burst_cnt, w_burst_nxt;
  logic            w_cpu_gnt, w_ldr_gnt;
  logic            r_cpu_rvalid, r_ldr_rvalid;

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    w_cpu_gnt   = 1'b0;
    w_ldr_gnt   = 1'b0;
    case (r_state)
      ARB: begin
        if (ldr_req && (!cpu_req || r_starve_cnt == SW'(STARVE_LIMIT))) begin
          w_ldr_gnt = 1'b1;
          if (ldr_lock && BURST_MAX > 1) begin
            w_state_nxt = BURST;
            w_burst_nxt = BW'(1);
          end
        end else if (cpu_req) begin
          w_cpu_gnt = 1'b1;
        end
      end
      BURST: begin
        w_ldr_gnt = ldr_req;
        if (ldr_req) w_burst_nxt = r_burst_cnt + BW'(1);
        // Exit is judged on the post-grant count so a burst never exceeds BURST_MAX grants.
        if (!ldr_lock || !ldr_req || w_burst_nxt == BW'(BURST_MAX)) begin
          w_state_nxt = ARB;
          w_burst_nxt = '0;
        end
      end
      default: w_state_nxt = ARB;
    endcase
    if (!reset_n) begin
      w_cpu_gnt = 1'b0;
      w_ldr_gnt = 1'b0;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!ldr_req || w_ldr_gnt)
      w_starve_nxt = '0;
    else if (w_cpu_gnt && r_starve_cnt != SW'(STARVE_LIMIT))
      w_starve_nxt = r_starve_cnt + SW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ARB;
      r_starve_cnt <= '0;
      r_burst_cnt  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_ldr_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_burst_cnt  <= w_burst_nxt;
      r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
      r_ldr_rvalid <= w_ldr_gnt & ~ldr_we;
    end
  end

  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (w_cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_ldr_gnt) begin
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  assign mem_en     = w_cpu_gnt | w_ldr_gnt;
  assign mem_we     = (w_cpu_gnt & cpu_we) | (w_ldr_gnt & ldr_we);
  assign cpu_gnt    = w_cpu_gnt;
  assign ldr_gnt    = w_ldr_gnt;
  assign cpu_stall  = reset_n & cpu_req & ~w_cpu_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign ldr_rvalid = r_ldr_rvalid;
  assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : 32'd0;
  assign ldr_rdata  = r_ldr_rvalid ? mem_rdata : 32'd0;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_conflict_cnt <= 16'd0;
    else if (cpu_req && ldr_req && r_conflict_cnt != 16'hFFFF)
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed grant/burst/reset scenarios
// plus a read-response scoreboard fed from grants and drained on rvalid.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid;
  logic [31:0] cpu_rdata, ldr_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;

  logic [31:0] mem_arr [256];

  typedef struct {
    logic        own_ldr;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4), .BURST_MAX(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  function automatic logic [31:0] init_val(input int a);
    return 32'h1000_0000 + 32'(a * 7);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr[7:0]];
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: responses drain before this cycle's read grants are queued.
  always @(negedge clk) begin
    if (reset_n) begin
      if (cpu_rvalid || ldr_rvalid) begin
        if (exp_q.size() == 0) begin
          chk_val("spurious_rvalid", {cpu_rvalid, ldr_rvalid}, 2'b00);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk_val("rvalid_owner", {cpu_rvalid, ldr_rvalid}, e.own_ldr ? 2'b01 : 2'b10);
          chk_val("rdata", e.own_ldr ? ldr_rdata : cpu_rdata, e.data);
        end
      end
      if (!cpu_rvalid) chk_val("cpu_rdata_idle", cpu_rdata, 0);
      if (!ldr_rvalid) chk_val("ldr_rdata_idle", ldr_rdata, 0);
      if (cpu_gnt && !cpu_we) exp_q.push_back('{1'b0, mem_arr[cpu_addr[7:0]]});
      if (ldr_gnt && !ldr_we) exp_q.push_back('{1'b1, mem_arr[ldr_addr[7:0]]});
    end
  end

  task automatic drive(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                       input logic [31:0] c_wd, input logic l_req, input logic l_we,
                       input logic l_lock, input logic [31:0] l_addr, input logic [31:0] l_wd);
    @(posedge clk);
    #2;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    ldr_req = l_req; ldr_we = l_we; ldr_lock = l_lock; ldr_addr = l_addr; ldr_wdata = l_wd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = init_val(i);
    mem_rdata = 32'd0;
    reset_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd3; cpu_wdata = 32'd0;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_lock = 1'b0; ldr_addr = 32'd4; ldr_wdata = 32'd0;
    #12;
    chk_val("rst_cpu_gnt", cpu_gnt, 0);
    chk_val("rst_ldr_gnt", ldr_gnt, 0);
    chk_val("rst_mem_en", mem_en, 0);
    chk_val("rst_rvalid", {cpu_rvalid, ldr_rvalid}, 0);
    chk_val("rst_conflict", conflict_cnt, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    cpu_req = 1'b0; ldr_req = 1'b0;

    // CPU-only write then read of the same word
    drive(1, 1, 7, 42, 0, 0, 0, 0, 0);
    chk_val("wr_gnt", cpu_gnt, 1);
    chk_val("wr_stall", cpu_stall, 0);
    chk_val("wr_mem", {mem_en, mem_we}, 2'b11);
    chk_val("wr_addr", mem_addr, 7);
    chk_val("wr_wdata", mem_wdata, 42);
    idle();
    chk_val("wr_no_rvalid", cpu_rvalid, 0);
    drive(1, 0, 7, 0, 0, 0, 0, 0, 0);
    chk_val("rd_gnt", cpu_gnt, 1);
    chk_val("rd_stall", cpu_stall, 0);
    chk_val("rd_mem_we", mem_we, 0);
    idle();
    chk_val("rd_rvalid", cpu_rvalid, 1);
    chk_val("rd_rdata", cpu_rdata, 42);
    chk_val("rd_ldr_rvalid", ldr_rvalid, 0);

    // Starvation: continuous conflict gives C,C,C,C,L
    for (int i = 0; i < 15; i++) begin
      logic exp_l;
      exp_l = (i % 5) == 4;
      drive(1, 0, 32'(30 + i), 0, 1, 0, 0, 32'(60 + i), 0);
      chk_val("starve_cpu_gnt", cpu_gnt, !exp_l);
      chk_val("starve_ldr_gnt", ldr_gnt, exp_l);
      chk_val("starve_stall", cpu_stall, exp_l);
      chk_val("starve_mem_addr", mem_addr, exp_l ? 32'(60 + i) : 32'(30 + i));
    end
    idle();

    // Burst cap: 4 CPU grants until starved, 16 locked loader grants, then CPU
    for (int i = 0; i < 21; i++) begin
      logic exp_l;
      exp_l = (i >= 4) && (i < 20);
      drive(1, 0, 32'(100 + i), 0, 1, 0, 1, 32'(130 + i), 0);
      chk_val("burst_ldr_gnt", ldr_gnt, exp_l);
      chk_val("burst_cpu_gnt", cpu_gnt, !exp_l);
      chk_val("burst_stall", cpu_stall, exp_l);
    end
    idle();
    idle();

    // Alternating single-owner reads on consecutive cycles
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        if (i % 2 == 0) drive(1, 0, 32'(20 + i), 0, 0, 0, 0, 0, 0);
        else            drive(0, 0, 0, 0, 1, 0, 0, 32'(20 + i), 0);
      end else begin
        idle();
      end
      if (i > 0) begin
        chk_val("alt_cpu_rvalid", cpu_rvalid, (i - 1) % 2 == 0);
        chk_val("alt_ldr_rvalid", ldr_rvalid, (i - 1) % 2 == 1);
        chk_val("alt_rdata", cpu_rdata | ldr_rdata, init_val(20 + i - 1));
      end
    end

    // Reset during a burst with a read outstanding
    drive(0, 0, 0, 0, 1, 0, 1, 50, 0);
    drive(0, 0, 0, 0, 1, 0, 1, 51, 0);
    chk_val("mid_ldr_gnt", ldr_gnt, 1);
    chk_val("mid_ldr_rvalid", ldr_rvalid, 1);
    #1;
    cpu_req = 1'b1;
    reset_n = 1'b0;
    #1;
    chk_val("mrst_gnts", {cpu_gnt, ldr_gnt}, 0);
    chk_val("mrst_mem_en", mem_en, 0);
    chk_val("mrst_mem_addr", mem_addr, 0);
    chk_val("mrst_rvalid", {cpu_rvalid, ldr_rvalid}, 0);
    chk_val("mrst_rdata", ldr_rdata, 0);
    chk_val("mrst_stall", cpu_stall, 0);
    exp_q.delete();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 60; cpu_wdata = 5;
    ldr_req = 1; ldr_we = 0; ldr_lock = 1; ldr_addr = 61;
    @(negedge clk);
    chk_val("post_arb_cpu_gnt", cpu_gnt, 1);
    chk_val("post_arb_ldr_gnt", ldr_gnt, 0);
    chk_val("post_rvalid0", {cpu_rvalid, ldr_rvalid}, 0);
    idle();
    chk_val("post_rvalid1", {cpu_rvalid, ldr_rvalid}, 0);
    idle();
    chk_val("post_rvalid2", {cpu_rvalid, ldr_rvalid}, 0);

    // Conflict counter over exactly 10 conflict cycles after a fresh reset
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    chk_val("perf_rst", conflict_cnt, 0);
    exp_q.delete();
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) drive(1, 1, 32'(200 + i), 32'(i), 1, 1, 0, 32'(220 + i), 32'(i));
    idle();
`ifdef DMEM_ARB_PERF_EN
    chk_val("perf_cnt", conflict_cnt, 10);
`else
    chk_val("perf_cnt", conflict_cnt, 0);
`endif
    idle();
    chk_val("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, the number of consecutive CPU grants allowed while the loader waits before the loader is forced a slot.
REQ-002 Parameter: BURST_MAX, default 16, the maximum number of consecutive loader grants while ldr_lock is held.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cpu_req, cpu_we  input  1,1  CPU datapath access request and write enable.
REQ-006 cpu_addr, cpu_wdata  input  32,32  CPU word address and write data.
REQ-007 cpu_gnt, cpu_stall  output  1,1  CPU access issued this cycle; CPU must hold its request.
REQ-008 cpu_rvalid, cpu_rdata  output  1,32  CPU read response.
REQ-009 ldr_req, ldr_we, ldr_lock  input  1,1,1  loader/debug request, write enable, burst lock.
REQ-010 ldr_addr, ldr_wdata  input  32,32  loader address and write data.
REQ-011 ldr_gnt, ldr_rvalid, ldr_rdata  output  1,1,32  loader grant, read response valid, read data.
REQ-012 mem_en, mem_we, mem_addr, mem_wdata  output  1,1,32,32  single-port data memory command.
REQ-013 mem_rdata  input  32  memory read data, valid one cycle after mem_en with mem_we=0.
REQ-014 conflict_cnt  output  16  count of cycles in which both requesters were active.

Function
REQ-015 FSM states SHALL be ARB and BURST.
- Arbitration is combinational from requests and registered state.
- At most one grant per cycle.
REQ-016 In ARB, the CPU SHALL win any conflict unless starve_cnt==STARVE_LIMIT, in which case the loader wins.
- A lone requester is always granted.
REQ-017 starve_cnt behaviour:
- +1 on each CPU grant while ldr_req=1.
- Clears to 0 on any loader grant or when ldr_req=0.
- Never exceeds STARVE_LIMIT.
REQ-018 A loader grant with ldr_lock=1 in ARB SHALL transition to BURST and load burst_cnt=1.
REQ-019 In BURST the loader SHALL be granted every cycle ldr_req=1.
- burst_cnt +1 per grant.
- Return to ARB when ldr_lock=0, ldr_req=0, or burst_cnt==BURST_MAX; that cycle is still a loader grant if ldr_req=1.
REQ-020 In BURST, cpu_req SHALL be stalled.
REQ-021 The mem_* outputs SHALL mux the granted requester's signals combinationally.
- mem_en = cpu_gnt|ldr_gnt; mem_we is the granted requester's write enable.
- mem_* are 0 with no grant.
REQ-022 cpu_stall SHALL equal cpu_req & ~cpu_gnt.
REQ-023 Read latency SHALL be exactly one cycle.
- A read granted in cycle N asserts the owner's rvalid in cycle N+1, with rdata=mem_rdata.
- Back-to-back reads, including alternating owners, are supported every cycle.
REQ-024 Writes SHALL produce no rvalid.
REQ-025 cpu_rdata and ldr_rdata SHALL be 0 when their rvalid is 0.

Reset
REQ-026 On reset_n=0, asynchronously:
- state=ARB; starve_cnt=0; burst_cnt=0; conflict_cnt=0.
- cpu_rvalid=0; ldr_rvalid=0; response owner cleared.
REQ-027 During reset, all grants and mem_en SHALL be 0.
REQ-028 Reset mid-burst or mid-read SHALL discard the pending response; no rvalid follows reset release.

Configuration
REQ-029 Macro DMEM_ARB_PERF_EN.
- Defined: conflict_cnt increments on each cycle with cpu_req&ldr_req, saturating at 16'hFFFF.
- Undefined: conflict_cnt is tied to 0 and no counter logic is built.

Verification
REQ-030 CPU-only path:
- Stimulus: CPU write addr 7 data 42, then read addr 7 two cycles later.
- Required: cpu_stall=0 throughout; cpu_rvalid one cycle after the read; cpu_rdata=42.
REQ-031 Starvation limit:
- Stimulus: cpu_req and ldr_req held high continuously with STARVE_LIMIT=4.
- Required grant pattern: C,C,C,C,L repeating; cpu_stall=1 only on the L cycles.
REQ-032 Burst cap:
- Stimulus: ldr_lock=1, ldr_req=1 for 20 cycles, cpu_req=1 throughout, BURST_MAX=16.
- Required: 16 consecutive loader grants, then exactly one CPU grant; cpu_stall=1 during the burst.
REQ-033 Alternating reads:
- Stimulus: alternating CPU/loader reads on consecutive cycles.
- Required: each rvalid lands on the correct owner at N+1 with matching data; no cross-delivery.
REQ-034 Reset mid-operation:
- Stimulus: reset_n pulsed low during BURST with a read outstanding.
- Required: all outputs 0 immediately; state=ARB after release; no rvalid after release.
REQ-035 Performance counter, with DMEM_ARB_PERF_EN defined:
- Stimulus: 10 conflict cycles.
- Required: conflict_cnt=10.
- Same stimulus with the macro undefined: conflict_cnt=0.
